slink_fifo_rd_stream: RTL

- Read-side front end for the async FIFO's read port, living entirely in the read clock domain.
- Pops words via the FIFO's rinc/rempty/rdata port and presents them as a registered valid/ready stream to downstream S-Link logic.
- Includes a 2-entry skid buffer, a synchronous flush/drain, an idle indication for driving clock-gate enables, and transfer/drop statistics counters.

---
 rtl/slink_fifo_rd_stream.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/slink_fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// slink_fifo_rd_stream
//
// Read-side front end for the async FIFO read port. It lives entirely in the
// read clock domain. It pops words through the FIFO's rinc/rempty/rdata port
// and presents them to downstream S-Link logic as a valid/ready stream.
//
// A 2-entry skid buffer (head/tail) decouples the FIFO pop strobe from
// downstream backpressure. Because of this, fifo_rinc never depends on i_ready.
//
// Handshake: a word transfers on a rising clk edge where o_valid=1 and
// i_ready=1. Once o_valid is raised, o_data stays stable until that transfer
// happens. The only exceptions are flush and reset, which withdraw o_valid.
//
// Ports:
//   clk, reset    read-domain clock; asynchronous active-high reset
//   fifo_rempty   FIFO empty flag
//   fifo_rdata    FIFO head word, meaningful while fifo_rempty=0
//   fifo_rinc     FIFO pop strobe
//   o_valid       output word valid
//   o_data        output word
//   i_ready       downstream accept
//   flush         synchronous drain: discard buffered words, empty the FIFO
//   clr_cnt       synchronous clear of both statistics counters
//   idle          nothing buffered and FIFO empty (clock-gate enable source)
//   xfer_cnt      completed output handshakes, wrapping
//   drop_cnt      words discarded by flush, saturating
//   dbg_state     occupancy state (0 EMPTY, 1 ONE, 2 TWO) for observation
// -----------------------------------------------------------------------------
module slink_fifo_rd_stream #(
    parameter int DATA_SIZE = 40,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_rempty,
    input  logic [DATA_SIZE-1:0] fifo_rdata,
    output logic                 fifo_rinc,
    output logic                 o_valid,
    output logic [DATA_SIZE-1:0] o_data,
    input  logic                 i_ready,
    input  logic                 flush,
    input  logic                 clr_cnt,
    output logic                 idle,
    output logic [CNT_W-1:0]     xfer_cnt,
    output logic [CNT_W-1:0]     drop_cnt,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state;
    logic [DATA_SIZE-1:0] head;
    logic [DATA_SIZE-1:0] tail;

    logic                 push;
    logic                 pop;
    logic [1:0]           held_cnt;
    logic [1:0]           drop_inc;
    logic [CNT_W+1:0]     drop_sum;
    logic [CNT_W-1:0]     drop_next;

    // During a flush the FIFO is drained regardless of buffer occupancy.
    assign fifo_rinc = ~reset & ~fifo_rempty & (flush | (state != TWO));
    assign push      = fifo_rinc & ~flush;
    assign o_valid   = (state != EMPTY) & ~flush;
    assign pop       = o_valid & i_ready;
    assign o_data    = head;
    assign idle      = fifo_rempty & (state == EMPTY);
    assign dbg_state = state;

    // Words lost to a flush in this cycle: the held words plus the word
    // popped from the FIFO. The held words can only be non-zero on the first
    // flush cycle, because flush forces EMPTY at the edge.
    always_comb begin
        held_cnt  = 2'd0;
        drop_inc  = 2'd0;
        drop_sum  = '0;
        drop_next = '0;
        case (state)
            ONE:     held_cnt = 2'd1;
            TWO:     held_cnt = 2'd2;
            default: held_cnt = 2'd0;
        endcase
        if (flush) begin
            drop_inc = held_cnt + {1'b0, fifo_rinc};
        end
        drop_sum = {2'b00, drop_cnt} + {{CNT_W{1'b0}}, drop_inc};
        // Saturate when any carry leaves the counter width (up to +3 per cycle).
        if (drop_sum[CNT_W+1:CNT_W] != 2'b00) begin
            drop_next = '1;
        end else begin
            drop_next = drop_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= EMPTY;
            head     <= '0;
            tail     <= '0;
            xfer_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (flush) begin
                // Head/tail keep their contents; only the occupancy is discarded.
                state <= EMPTY;
            end else begin
                case (state)
                    EMPTY: begin
                        if (push) begin
                            state <= ONE;
                            head  <= fifo_rdata;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            head <= fifo_rdata;
                        end else if (push) begin
                            state <= TWO;
                            tail  <= fifo_rdata;
                        end else if (pop) begin
                            state <= EMPTY;
                        end
                    end
                    TWO: begin
                        // fifo_rinc is held low in TWO, so no push can arrive here.
                        if (pop) begin
                            state <= ONE;
                            head  <= tail;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end

            if (clr_cnt) begin
                xfer_cnt <= '0;
                drop_cnt <= '0;
            end else begin
                xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, pop};
                drop_cnt <= drop_next;
            end
        end
    end

endmodule
